// File: rtl/obj_dma_ctrl_if.sv
// Bus bundle for the sprite object DMA controller: CPU-side request and
// status, the source object-RAM read port and the destination line-buffer
// write port. The controller uses the master modport, and the surrounding
// level uses the slave modport.
interface obj_dma_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              ce;
  logic              start;
  logic              busy;
  logic              done;
  logic              bank;
  logic              src_own;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_q;
  logic              dst_we;
  logic [ADDR_W:0]   dst_addr;
  logic [DATA_W-1:0] dst_data;

  modport master (
    input  ce, start, src_q,
    output busy, done, bank, src_own, src_addr, dst_we, dst_addr, dst_data
  );

  modport slave (
    output ce, start, src_q,
    input  busy, done, bank, src_own, src_addr, dst_we, dst_addr, dst_data
  );
endinterface

// File: rtl/obj_dma_ctrl.sv
// Sprite object DMA controller. A start request copies COUNT words from the
// object RAM (registered read port) into the current bank of a double-buffered
// line-buffer RAM. Each word takes WAITCE -> FETCH -> LATCH. The last write
// still targets the old bank, and the bank flips on that same edge.
module obj_dma_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int COUNT  = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  obj_dma_ctrl_if.master       bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAITCE = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_LATCH  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COUNT - 1);

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              busy_r;
  logic              done_r;
  logic              bank_r;
  logic              src_own_r;
  logic              dst_we_r;
  logic [ADDR_W:0]   dst_addr_r;
  logic [DATA_W-1:0] dst_data_r;

  // Copy sequencer: walks idx through the object RAM, one word per accepted ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bank_r     <= 1'b0;
      src_own_r  <= 1'b0;
      dst_we_r   <= 1'b0;
      dst_addr_r <= {(ADDR_W+1){1'b0}};
      dst_data_r <= {DATA_W{1'b0}};
    end else begin
      // Strobes are single-cycle unless re-armed below.
      done_r   <= 1'b0;
      dst_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_WAITCE;
            idx_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAITCE: begin
          if (bus.ce) begin
            state_r   <= ST_FETCH;
            src_own_r <= 1'b1;
          end else begin
            state_r <= ST_WAITCE;
          end
        end
        ST_FETCH: begin
          // The RAM samples src_addr (= idx) at the end of this clock.
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          // src_q now holds word idx; the write uses the bank before any flip.
          dst_we_r   <= 1'b1;
          dst_addr_r <= {bank_r, idx_r};
          dst_data_r <= bus.src_q;
          src_own_r  <= 1'b0;
          if (idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            bank_r  <= ~bank_r;
            idx_r   <= {ADDR_W{1'b0}};
          end else begin
            state_r <= ST_WAITCE;
            idx_r   <= idx_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          src_own_r <= 1'b0;
          idx_r     <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bank     = bank_r;
  assign bus.src_own  = src_own_r;
  assign bus.src_addr = idx_r;
  assign bus.dst_we   = dst_we_r;
  assign bus.dst_addr = dst_addr_r;
  assign bus.dst_data = dst_data_r;

endmodule

// File: tb/tb_obj_dma_ctrl.sv
// Testbench for obj_dma_ctrl. Each scenario has per-edge start and ce sequences.
// A reference model derives per-clock expectations from the copy rules:
// a word is accepted on the first ce edge at or after the ready edge.
// FETCH and LATCH follow, and the write is visible 3 clocks after acceptance.
module tb_obj_dma_ctrl;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int NMAX = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  obj_dma_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
  obj_dma_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  obj_dma_ctrl #(.ADDR_W(AW), .DATA_W(DW), .COUNT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  obj_dma_ctrl #(.ADDR_W(AW), .DATA_W(DW), .COUNT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [DW-1:0] src_mem [0:(1<<AW)-1];

  // Source object RAM with a registered read port (shared contents for both DUTs).
  always @(posedge clk) begin
    bus4.src_q <= src_mem[bus4.src_addr];
    bus1.src_q <= src_mem[bus1.src_addr];
  end

  int total = 0;
  int bad   = 0;

  logic          ce_seq  [0:NMAX];
  logic          st_seq  [0:NMAX];
  // Control vector layout: {busy, done, bank, src_own, dst_we}
  logic [4:0]    obs_ctl [0:NMAX];
  logic [4:0]    exp_ctl [0:NMAX];
  logic [AW:0]   obs_addr[0:NMAX];
  logic [AW:0]   exp_addr[0:NMAX];
  logic [DW-1:0] obs_data[0:NMAX];
  logic [DW-1:0] exp_data[0:NMAX];
  logic          bank4_m = 1'b0;
  logic          bank1_m = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int k = 0; k <= NMAX; k++) begin
      ce_seq[k] = 1'b0;
      st_seq[k] = 1'b0;
    end
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < (1 << AW); i++) src_mem[i] = DW'($urandom);
  endtask

  // Reference model: every copy accepted within the first n edges, at word level.
  task automatic build_expect(input int cnt, input int n, input logic b0, output logic bend);
    int s, nxt, ready, e, d;
    logic b, bc;
    b = b0;
    for (int k = 0; k <= NMAX; k++) begin
      exp_ctl[k] = 5'b0; exp_addr[k] = '0; exp_data[k] = '0;
    end
    nxt = 0;
    while (nxt < n) begin
      s = nxt;
      while (s < n && !st_seq[s]) s++;
      if (s >= n) break;
      ready = s + 1;
      for (int i = 0; i < cnt; i++) begin
        e = ready;
        while (e < NMAX - 3 && !ce_seq[e]) e++;
        exp_ctl[e+1][1] = 1'b1;
        exp_ctl[e+2][1] = 1'b1;
        exp_ctl[e+3][0] = 1'b1;
        exp_addr[e+3]   = {b, AW'(i)};
        exp_data[e+3]   = src_mem[i];
        ready = e + 3;
      end
      d = ready;
      exp_ctl[d][3] = 1'b1;
      for (int k = s + 1; k < d; k++) exp_ctl[k][4] = 1'b1;
      b   = ~b;
      nxt = d;
    end
    bc = b0;
    for (int k = 1; k <= NMAX; k++) begin
      if (exp_ctl[k][3]) bc = ~bc;
      exp_ctl[k][2] = bc;
    end
    bend = b;
  endtask

  // Drive the sequences into one DUT for n edges, and log clocks 1..n.
  task automatic run_scn(input int sel, input int n, input int rst_edge);
    for (int j = 0; j < n; j++) begin
      reset      = (j == rst_edge);
      bus4.start = (sel == 4) ? st_seq[j] : 1'b0;
      bus4.ce    = (sel == 4) ? ce_seq[j] : 1'b0;
      bus1.start = (sel == 1) ? st_seq[j] : 1'b0;
      bus1.ce    = (sel == 1) ? ce_seq[j] : 1'b0;
      tick();
      if (sel == 4) begin
        obs_ctl[j+1]  = {bus4.busy, bus4.done, bus4.bank, bus4.src_own, bus4.dst_we};
        obs_addr[j+1] = bus4.dst_addr;
        obs_data[j+1] = bus4.dst_data;
      end else begin
        obs_ctl[j+1]  = {bus1.busy, bus1.done, bus1.bank, bus1.src_own, bus1.dst_we};
        obs_addr[j+1] = bus1.dst_addr;
        obs_data[j+1] = bus1.dst_data;
      end
    end
    reset = 1'b0;
    bus4.start = 1'b0; bus4.ce = 1'b0; bus1.start = 1'b0; bus1.ce = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({bus4.busy, bus4.done, bus4.bank, bus4.src_own, bus4.src_addr, bus4.dst_we, bus4.dst_addr, bus4.dst_data} !== '0) begin
      bad++;
      $display("FAIL reset4 got busy=%b done=%b bank=%b own=%b sa=%h we=%b da=%h dd=%h want all 0",
               bus4.busy, bus4.done, bus4.bank, bus4.src_own, bus4.src_addr, bus4.dst_we, bus4.dst_addr, bus4.dst_data);
    end
    total++;
    if ({bus1.busy, bus1.done, bus1.bank, bus1.src_own, bus1.src_addr, bus1.dst_we, bus1.dst_addr, bus1.dst_data} !== '0) begin
      bad++;
      $display("FAIL reset1 outputs not at reset values");
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_seq();
    for (int i = 0; i < 4; i++) src_mem[i] = DW'(16'h1111 * (i + 1));
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = 1'b1;
    st_seq[0] = 1'b1;
    build_expect(4, 20, bank4_m, bank4_m);
    run_scn(4, 20, -1);
    for (int k = 1; k <= 20; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL basic_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL basic_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_ctl[4+3*i][0] !== 1'b1 || obs_addr[4+3*i] !== 10'(i) || obs_data[4+3*i] !== 16'(16'h1111 * (i + 1))) begin
        bad++; $display("FAIL basic_fixed word=%0d we=%b addr=%h data=%h", i, obs_ctl[4+3*i][0], obs_addr[4+3*i], obs_data[4+3*i]);
      end
    end
    total++;
    if (obs_ctl[13][3] !== 1'b1 || obs_ctl[13][4] !== 1'b0 || obs_ctl[14][2] !== 1'b1) begin
      bad++; $display("FAIL basic_done done13=%b busy13=%b bank14=%b want 1 0 1", obs_ctl[13][3], obs_ctl[13][4], obs_ctl[14][2]);
    end
  endtask

  task automatic test_second_bank();
    clear_seq();
    fill_mem_random();
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = 1'b1;
    st_seq[0] = 1'b1;
    build_expect(4, 20, bank4_m, bank4_m);
    run_scn(4, 20, -1);
    for (int k = 1; k <= 20; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL bank2_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL bank2_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    total++;
    if (obs_addr[4] !== 10'h200 || obs_addr[13] !== 10'h203 || obs_ctl[14][2] !== 1'b0) begin
      bad++; $display("FAIL bank2_fixed addr4=%h addr13=%h bank14=%b want 200 203 0", obs_addr[4], obs_addr[13], obs_ctl[14][2]);
    end
  endtask

  task automatic test_slow_ce();
    int own_cnt, we_cnt;
    clear_seq();
    fill_mem_random();
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = (k % 8 == 0);
    st_seq[0] = 1'b1;
    build_expect(4, 45, bank4_m, bank4_m);
    run_scn(4, 45, -1);
    own_cnt = 0; we_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      own_cnt += int'(obs_ctl[k][1]);
      we_cnt  += int'(obs_ctl[k][0]);
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL slow_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL slow_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    total++;
    if (own_cnt != 8 || we_cnt != 4 || obs_ctl[11][0] !== 1'b1 || obs_ctl[19][0] !== 1'b1) begin
      bad++; $display("FAIL slow_count own=%0d we=%0d we11=%b we19=%b want 8 4 1 1", own_cnt, we_cnt, obs_ctl[11][0], obs_ctl[19][0]);
    end
  endtask

  task automatic test_back_to_back();
    int we_cnt, done_cnt;
    clear_seq();
    fill_mem_random();
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = 1'b1;
    for (int k = 0; k <= 13; k++) st_seq[k] = 1'b1;
    build_expect(4, 40, bank4_m, bank4_m);
    run_scn(4, 40, -1);
    we_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 13) begin
        we_cnt   += int'(obs_ctl[k][0]);
        done_cnt += int'(obs_ctl[k][3]);
      end
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL b2b_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL b2b_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    total++;
    if (we_cnt != 4 || done_cnt != 1 || obs_ctl[14][4] !== 1'b1) begin
      bad++; $display("FAIL b2b_count we=%0d done=%0d busy14=%b want 4 1 1", we_cnt, done_cnt, obs_ctl[14][4]);
    end
  endtask

  task automatic test_random();
    clear_seq();
    fill_mem_random();
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = ($urandom_range(0, 1) == 1);
    for (int k = 0; k < 140; k++) st_seq[k] = ($urandom_range(0, 9) < 3);
    build_expect(4, 200, bank4_m, bank4_m);
    run_scn(4, 200, -1);
    for (int k = 1; k <= 200; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL rand_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL rand_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic dummy;
    clear_seq();
    for (int k = 0; k <= NMAX; k++) ce_seq[k] = 1'b1;
    st_seq[0] = 1'b1;
    if (!bank4_m) begin
      build_expect(4, 20, bank4_m, bank4_m);
      run_scn(4, 20, -1);
    end
    fill_mem_random();
    build_expect(4, 10, bank4_m, dummy);
    run_scn(4, 20, 10);
    for (int k = 1; k <= 10; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL rstmid_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
    end
    total++;
    if ({obs_ctl[11], obs_addr[11], obs_data[11]} !== '0 || obs_ctl[20] !== 5'b0) begin
      bad++; $display("FAIL rstmid_zero ctl=%b addr=%h data=%h ctl20=%b want 0", obs_ctl[11], obs_addr[11], obs_data[11], obs_ctl[20]);
    end
    bank4_m = 1'b0;
    fill_mem_random();
    build_expect(4, 20, bank4_m, bank4_m);
    run_scn(4, 20, -1);
    for (int k = 1; k <= 20; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL recopy_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_ctl[k][0]) begin
        total++;
        if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          bad++; $display("FAIL recopy_wr clk=%0d got=%h/%h want=%h/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    total++;
    if (obs_addr[4] !== 10'h000 || obs_data[4] !== src_mem[0]) begin
      bad++; $display("FAIL recopy_first addr=%h data=%h want 000/%h", obs_addr[4], obs_data[4], src_mem[0]);
    end
  endtask

  task automatic test_count1();
    int we_cnt;
    clear_seq();
    fill_mem_random();
    for (int k = 6; k <= NMAX; k++) ce_seq[k] = 1'b1;
    st_seq[0] = 1'b1;
    build_expect(1, 20, bank1_m, bank1_m);
    run_scn(1, 20, -1);
    we_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      we_cnt += int'(obs_ctl[k][0]);
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++; $display("FAIL c1_ctl clk=%0d got=%b want=%b", k, obs_ctl[k], exp_ctl[k]);
      end
    end
    total++;
    if (we_cnt != 1 || obs_ctl[9][0] !== 1'b1 || obs_ctl[9][3] !== 1'b1 || obs_addr[9] !== 10'h000 || obs_data[9] !== src_mem[0]) begin
      bad++; $display("FAIL c1_write cnt=%0d we9=%b done9=%b addr=%h data=%h want 1 1 1 000 %h",
                      we_cnt, obs_ctl[9][0], obs_ctl[9][3], obs_addr[9], obs_data[9], src_mem[0]);
    end
  endtask

  initial begin
    bus4.start = 1'b0; bus4.ce = 1'b0; bus1.start = 1'b0; bus1.ce = 1'b0;
    for (int i = 0; i < (1 << AW); i++) src_mem[i] = '0;
    test_reset();
    test_basic();
    test_second_bank();
    test_slow_ce();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_count1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
